// File: rtl/prog_clk_div.sv
// Programmable clock divider with a runtime-configurable period and high time.
// New settings are held in shadow registers and take effect only at a period boundary.
module prog_clk_div #(
    parameter int unsigned          WIDTH       = 28,
    parameter logic [WIDTH-1:0]     DEFAULT_DIV = 28'd202429
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] hi_in,
    output logic             clock_out,
    output logic             tick,
    output logic             pending,
    output logic             cfg_err
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] DefaultHi = DEFAULT_DIV >> 1;
    localparam logic [WIDTH-1:0] One       = WIDTH'(1);
    localparam logic [WIDTH-1:0] Two       = WIDTH'(2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] hi_act_q, hi_act_d;
    logic [WIDTH-1:0] div_sh_q, div_sh_d;
    logic [WIDTH-1:0] hi_sh_q, hi_sh_d;
    logic             pending_q, pending_d;
    logic             cfg_err_q, cfg_err_d;
    logic             clock_out_q, clock_out_d;
    logic             tick_q, tick_d;

    logic             load_ok;
    logic             wrap;
    logic [WIDTH-1:0] hi_clamp;

    always_comb begin
        load_ok  = load && (div_in >= Two);
        wrap     = (cnt_q >= div_act_q - One);
        hi_clamp = hi_in;
        if (hi_in == '0) begin
            hi_clamp = One;
        end else if (hi_in >= div_in) begin
            hi_clamp = div_in - One;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        hi_act_d  = hi_act_q;
        div_sh_d  = div_sh_q;
        hi_sh_d   = hi_sh_q;
        pending_d = pending_q;
        cfg_err_d = load && !load_ok;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (load_ok) begin
                    div_act_d = div_in;
                    hi_act_d  = hi_clamp;
                end
                if (enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!enable) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    if (pending_q) begin
                        div_act_d = div_sh_q;
                        hi_act_d  = hi_sh_q;
                    end
                    // A load on the way out has nowhere to wait, so it goes live directly.
                    if (load_ok) begin
                        div_act_d = div_in;
                        hi_act_d  = hi_clamp;
                    end
                end else begin
                    if (wrap) begin
                        cnt_d = '0;
                        if (pending_q) begin
                            div_act_d = div_sh_q;
                            hi_act_d  = hi_sh_q;
                            pending_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + One;
                    end
                    // Overwrites the shadow after it has been consumed at this boundary.
                    if (load_ok) begin
                        div_sh_d  = div_in;
                        hi_sh_d   = hi_clamp;
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from next-state so they line up with cnt_q.
        clock_out_d = (state_d == StRun) && (cnt_d < hi_act_d);
        tick_d      = (state_d == StRun) && (cnt_d == '0);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            div_act_q   <= DEFAULT_DIV;
            hi_act_q    <= DefaultHi;
            div_sh_q    <= DEFAULT_DIV;
            hi_sh_q     <= DefaultHi;
            pending_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            clock_out_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_act_q   <= div_act_d;
            hi_act_q    <= hi_act_d;
            div_sh_q    <= div_sh_d;
            hi_sh_q     <= hi_sh_d;
            pending_q   <= pending_d;
            cfg_err_q   <= cfg_err_d;
            clock_out_q <= clock_out_d;
            tick_q      <= tick_d;
        end
    end

    assign clock_out = clock_out_q;
    assign tick      = tick_q;
    assign pending   = pending_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div (WIDTH=8, DEFAULT_DIV=6); expected outputs are queued
// with each stimulus step and compared one cycle later.
module tb_prog_clk_div;

    logic       clock_in = 1'b0;
    logic       reset    = 1'b1;
    logic       enable   = 1'b0;
    logic       load     = 1'b0;
    logic [7:0] div_in   = '0;
    logic [7:0] hi_in    = '0;
    logic       clock_out;
    logic       tick;
    logic       pending;
    logic       cfg_err;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] exp_q[$];

    prog_clk_div #(
        .WIDTH      (8),
        .DEFAULT_DIV(8'd6)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .enable   (enable),
        .load     (load),
        .div_in   (div_in),
        .hi_in    (hi_in),
        .clock_out(clock_out),
        .tick     (tick),
        .pending  (pending),
        .cfg_err  (cfg_err)
    );

    always #5 clock_in = ~clock_in;

    // exp = {clock_out, tick, pending, cfg_err} expected after the edge that samples the inputs.
    task automatic cyc(input string tag, input logic r, input logic en, input logic ld,
                       input logic [7:0] dv, input logic [7:0] hv, input logic [3:0] exp);
        logic [3:0] e;
        logic [3:0] obs;
        reset  = r;
        enable = en;
        load   = ld;
        div_in = dv;
        hi_in  = hv;
        exp_q.push_back(exp);
        @(posedge clock_in);
        #1;
        e   = exp_q.pop_front();
        obs = {clock_out, tick, pending, cfg_err};
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s: {clk,tick,pend,err} observed=%b expected=%b", tag, obs, e);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] exp);
        cyc(tag, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, exp);
    endtask

    initial begin
        // Reset overrides enable and load
        cyc("rst_ovr", 1'b1, 1'b1, 1'b1, 8'd4, 8'd1, 4'b0000);
        cyc("rst_idle", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'b0000);

        // Default 6-cycle pattern 1,1,1,0,0,0
        for (int p = 0; p < 2; p++) begin
            run("def_c0", 4'b1100);
            run("def_c1", 4'b1000);
            run("def_c2", 4'b1000);
            run("def_c3", 4'b0000);
            run("def_c4", 4'b0000);
            run("def_c5", 4'b0000);
        end

        // Load div4/hi1 sampled at cnt=2; current period finishes, then 1,0,0,0
        run("ld_c0", 4'b1100);
        run("ld_c1", 4'b1000);
        run("ld_c2", 4'b1000);
        cyc("ld_c3", 1'b0, 1'b1, 1'b1, 8'd4, 8'd1, 4'b0010);
        run("ld_c4", 4'b0010);
        run("ld_c5", 4'b0010);
        run("new_c0", 4'b1100);
        run("new_c1", 4'b0000);
        run("new_c2", 4'b0000);
        run("new_c3", 4'b0000);
        run("new_c0b", 4'b1100);

        // Rejected load: error pulse, period unchanged at 4
        cyc("bad_err", 1'b0, 1'b1, 1'b1, 8'd1, 8'd0, 4'b0001);
        run("bad_c2", 4'b0000);
        run("bad_c3", 4'b0000);
        run("bad_c0", 4'b1100);

        // Idle load div5/hi9 clamps hi to 4
        cyc("idle_in", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'b0000);
        cyc("idle_ld", 1'b0, 1'b0, 1'b1, 8'd5, 8'd9, 4'b0000);
        for (int p = 0; p < 2; p++) begin
            run("clamp_c0", 4'b1100);
            run("clamp_c1", 4'b1000);
            run("clamp_c2", 4'b1000);
            run("clamp_c3", 4'b1000);
            run("clamp_c4", 4'b0000);
        end

        // Two loads in one period: last (div8/hi2) wins
        run("two_c0", 4'b1100);
        cyc("two_c1", 1'b0, 1'b1, 1'b1, 8'd4, 8'd0, 4'b1010);
        cyc("two_c2", 1'b0, 1'b1, 1'b1, 8'd8, 8'd2, 4'b1010);
        run("two_c3", 4'b1010);
        run("two_c4", 4'b0010);
        run("p8_c0", 4'b1100);
        run("p8_c1", 4'b1000);
        for (int i = 2; i < 8; i++) run("p8_low", 4'b0000);
        run("p8_c0b", 4'b1100);

        // Enable drop while pending applies shadow on entry to idle
        cyc("drop_ld", 1'b0, 1'b1, 1'b1, 8'd3, 8'd1, 4'b1010);
        cyc("drop_idle", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'b0000);
        run("p3_c0", 4'b1100);
        run("p3_c1", 4'b0000);
        run("p3_c2", 4'b0000);
        run("p3_c0b", 4'b1100);

        // Reset mid-period with pending discards the shadow
        cyc("rp_ld6", 1'b0, 1'b1, 1'b1, 8'd6, 8'd3, 4'b0010);
        run("rp_c2", 4'b0010);
        run("rp_c0", 4'b1100);
        run("rp_c1", 4'b1000);
        run("rp_c2b", 4'b1000);
        cyc("rp_ld4", 1'b0, 1'b1, 1'b1, 8'd4, 8'd1, 4'b0010);
        cyc("rp_rst", 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 4'b0000);
        run("rr_c0", 4'b1100);
        run("rr_c1", 4'b1000);
        run("rr_c2", 4'b1000);
        run("rr_c3", 4'b0000);
        run("rr_c4", 4'b0000);
        run("rr_c5", 4'b0000);
        run("rr_c0b", 4'b1100);

        // Minimum divisor: div2/hi1 toggles every cycle
        cyc("d2_ld", 1'b0, 1'b1, 1'b1, 8'd2, 8'd1, 4'b1010);
        run("d2_w2", 4'b1010);
        run("d2_w3", 4'b0010);
        run("d2_w4", 4'b0010);
        run("d2_w5", 4'b0010);
        for (int p = 0; p < 3; p++) begin
            run("d2_hi", 4'b1100);
            run("d2_lo", 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 Parameter WIDTH, default 28, SHALL set the width of the counter and of the divisor/high-time inputs.
REQ-002 Parameter DEFAULT_DIV, default 28'd202429, SHALL be the divisor after reset.
REQ-003 Port clock_in, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: 1 = run the divider, 0 = idle.
REQ-006 Port load, input, 1: one-cycle strobe that requests a new configuration.
REQ-007 Port div_in, input, WIDTH: requested period in clock_in cycles.
REQ-008 Port hi_in, input, WIDTH: requested high time in clock_in cycles.
REQ-009 Port clock_out, output, 1: registered divided clock.
REQ-010 Port tick, output, 1: one-cycle pulse in the first cycle of each period.
REQ-011 Port pending, output, 1: high while an accepted configuration waits to be applied.
REQ-012 Port cfg_err, output, 1: one-cycle pulse when a load is rejected.

Function
REQ-013 Internal state: IDLE and RUN; active registers div_act and hi_act; shadow registers div_sh and hi_sh; counter cnt.
REQ-014 IDLE: cnt = 0, clock_out = 0, tick = 0; IDLE→RUN in the cycle after enable = 1 is sampled.
REQ-015 RUN: cnt increments by 1 each cycle and wraps from div_act-1 to 0 (mod div_act, no overflow).
REQ-016 RUN: clock_out = 1 exactly in cycles where cnt < hi_act, otherwise 0; first RUN cycle has cnt = 0, so clock_out = 1 and tick = 1.
REQ-017 RUN: tick = 1 exactly in cycles where cnt = 0.
REQ-018 RUN→IDLE in the cycle after enable = 0 is sampled, regardless of cnt; outputs go to IDLE values in that same next cycle.
REQ-019 Load validity: a load with div_in < 2 SHALL be rejected; cfg_err = 1 the next cycle; shadow, active and pending registers unchanged.
REQ-020 Load clamping: a valid load clamps hi to the range 1..div_in-1 (0→1; ≥div_in→div_in-1) before storing.
REQ-021 Valid load in IDLE: the configuration goes straight into div_act/hi_act the next cycle; pending stays 0.
REQ-022 Valid load in RUN: the configuration goes into the shadow registers; pending = 1 the next cycle.
REQ-023 Load while pending = 1: overwrites the shadow (last load wins).
REQ-024 Apply point: when cnt = div_act-1 and pending = 1, the shadow is copied to active and pending clears; the next cycle is cnt = 0 with the new values, so no truncated or runt period occurs.
REQ-025 Load in the same cycle as the apply point:
- with pending = 0, the load is stored in the shadow and applied at the following boundary;
- with pending = 1, the old shadow is applied and the new load becomes pending.
REQ-026 enable dropping while pending = 1: the shadow is applied on entry to IDLE and pending clears.
REQ-027 div_act = 2 and hi_act = 1: clock_out toggles every cycle; tick on every other cycle.

Reset
REQ-028 reset = 1 SHALL take effect at the next rising edge and SHALL override enable and load.
REQ-029 Reset values:
- state = IDLE, cnt = 0;
- div_act = div_sh = DEFAULT_DIV; hi_act = hi_sh = DEFAULT_DIV/2 (integer division);
- clock_out = tick = pending = cfg_err = 0.
REQ-030 Reset in the middle of a period SHALL discard any pending configuration.

Verification (WIDTH=8, DEFAULT_DIV=6)
REQ-031 Reset, then enable = 1 held → clock_out repeats 1,1,1,0,0,0; tick high on every 6th cycle, starting in the first RUN cycle.
REQ-032 In RUN, load with div_in = 4, hi_in = 1 at cnt = 2 → pending = 1; the current 6-cycle period completes; the next period is 1,0,0,0; pending clears at the boundary.
REQ-033 load with div_in = 1 → cfg_err pulses once; the period stays 6; pending = 0.
REQ-034 load with div_in = 5, hi_in = 9 in IDLE, then enable → pattern 1,1,1,1,0 (hi clamped to 4).
REQ-035 Two loads during one period (div 4, then div 8 with hi 2) → the next period is 8 cycles with 2 high; there is no 4-cycle period.
REQ-036 reset asserted at cnt = 3 with pending = 1 → the next cycle shows IDLE values and pending = 0; re-enabling gives the 6-cycle pattern.
